// File: rtl/adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_share_arb
// Brief    : Round-robin arbiter + 2-stage issue pipeline sharing one external
//            combinational adder among N_REQ requesters; tagged registered sum.
// Revision : 1.0
// ============================================================================
module adder_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       add_in_1,
  output logic [WIDTH-1:0]       add_in_2,
  input  logic [WIDTH-1:0]       add_sum,
  output logic [WIDTH-1:0]       result,
  output logic [ID_W-1:0]        result_id,
  output logic                   result_valid,
  input  logic                   result_ready
);

  logic [WIDTH-1:0] w_op_a [N_REQ];
  logic [WIDTH-1:0] w_op_b [N_REQ];

  logic [ID_W-1:0]  r_ptr;
  logic             r_s1_v;
  logic [ID_W-1:0]  r_s1_id;

  logic             w_s2_acc;
  logic             w_s1_acc;
  logic             w_gnt_any;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W-1:0]  w_ptr_nxt;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign w_op_a[i] = op_a[i*WIDTH +: WIDTH];
      assign w_op_b[i] = op_b[i*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_s2_acc = !result_valid || result_ready;
  assign w_s1_acc = !r_s1_v || w_s2_acc;

  // Scan ptr, ptr+1, ... with wrap; the first requester found wins.
  always_comb begin
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!w_gnt_any && req[scan_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = scan_idx;
      end
    end
    // Held-off while stage 1 is stalled, and forced quiet during reset.
    if (!w_s1_acc || !rst_n) begin
      w_gnt_any = 1'b0;
    end
  end

  assign gnt       = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);

  // Stage 1: operand registers feeding the shared adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_id  <= '0;
      add_in_1 <= '0;
      add_in_2 <= '0;
    end else if (w_s1_acc) begin
      if (w_gnt_any) begin
        add_in_1 <= w_op_a[w_gnt_idx];
        add_in_2 <= w_op_b[w_gnt_idx];
        r_s1_id  <= w_gnt_idx;
        r_s1_v   <= 1'b1;
        r_ptr    <= w_ptr_nxt;
      end else begin
        r_s1_v   <= 1'b0;
      end
    end
  end

  // Stage 2: captures the adder output together with its owner tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
    end else if (w_s2_acc) begin
      result       <= add_sum;
      result_id    <= r_s1_id;
      result_valid <= r_s1_v;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_share_arb
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a grant-order/occupancy reference model.
// Revision : 1.0
// ============================================================================
module tb_adder_share_arb;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] op_a = '0;
  logic [N_REQ*WIDTH-1:0] op_b = '0;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       add_in_1;
  logic [WIDTH-1:0]       add_in_2;
  logic [WIDTH-1:0]       add_sum;
  logic [WIDTH-1:0]       result;
  logic [ID_W-1:0]        result_id;
  logic                   result_valid;
  logic                   result_ready = 1'b0;

  adder_share_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .gnt          (gnt),
    .add_in_1     (add_in_1),
    .add_in_2     (add_in_2),
    .add_sum      (add_sum),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // The shared external adder.
  assign add_sum = add_in_1 + add_in_2;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight ops in grant order with their grant cycle.
  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sum;
    int               gcyc;
  } item_t;

  item_t            q[$];
  int               mptr      = 0;
  int               cyc       = 0;
  int               last_cons = -100;
  logic [N_REQ-1:0] obs_gnt;

  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ*WIDTH-1:0] lanes(input int sel, input logic [31:0] v,
                                                  input logic [31:0] fill);
    logic [N_REQ*WIDTH-1:0] x;
    for (int j = 0; j < N_REQ; j++) x[j*WIDTH +: WIDTH] = (j == sel) ? v : fill + 32'(j);
    return x;
  endfunction

  // Enter and leave at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    mptr      = 0;
    last_cons = -100;
  endtask

  // One cycle checked against the model: an op granted at T is visible from
  // max(T+2, cycle after the previous result was taken); a new grant is
  // possible unless two ops are outstanding and the front is not taken now.
  task automatic model_cycle(input logic [N_REQ-1:0] r, input logic [N_REQ*WIDTH-1:0] a,
                             input logic [N_REQ*WIDTH-1:0] b, input logic rdy);
    logic             vis;
    logic             acc;
    int               pick;
    logic [N_REQ-1:0] eg;
    req = r; op_a = a; op_b = b; result_ready = rdy;
    #1;
    vis = (q.size() > 0) && (cyc >= q[0].gcyc + 2) && (cyc >= last_cons + 1);
    chk("model_valid", 32'(result_valid), 32'(vis));
    if (vis) begin
      chk("model_result", result, q[0].sum);
      chk("model_id", 32'(result_id), 32'(q[0].id));
    end
    acc  = (q.size() < 2) || (vis && rdy);
    pick = acc ? rr_pick(r, mptr) : -1;
    eg   = (pick >= 0) ? (N_REQ'(1) << pick) : '0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    obs_gnt = gnt;
    if (vis && rdy) begin
      void'(q.pop_front());
      last_cons = cyc;
    end
    if (pick >= 0) begin
      q.push_back('{id: pick[ID_W-1:0],
                    sum: a[pick*WIDTH +: WIDTH] + b[pick*WIDTH +: WIDTH],
                    gcyc: cyc});
      mptr = (pick + 1) % N_REQ;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [N_REQ-1:0] exp_gnt;
    logic [ID_W-1:0]  exp_id;
    logic [WIDTH-1:0] exp_sum;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0100, 32'd5,          32'd7,          4'b0100, 2'd2, 32'd12};
    tbl[1] = '{4'b0001, 32'hFFFF_FFFF,  32'h0000_0002,  4'b0001, 2'd0, 32'h0000_0001};
    tbl[2] = '{4'b1010, 32'd100,        32'd200,        4'b0010, 2'd1, 32'd300};
    tbl[3] = '{4'b1000, 32'h8000_0000,  32'h8000_0000,  4'b1000, 2'd3, 32'h0};
    tbl[4] = '{4'b1111, 32'd123,        32'd456,        4'b0001, 2'd0, 32'd579};
    tbl[5] = '{4'b0000, 32'd1,          32'd1,          4'b0000, 2'd0, 32'd0};

    #2;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_add_in_1", add_in_1, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Table: single op from a fresh reset (ptr=0), full latency profile.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      result_ready = 1'b1;
      req  = tbl[i].req;
      op_a = lanes(int'(tbl[i].exp_id), tbl[i].a, 32'hA5A5_0000);
      op_b = lanes(int'(tbl[i].exp_id), tbl[i].b, 32'h5A5A_0000);
      #1;
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].exp_gnt));
      @(posedge clk); #1;
      req = '0;
      chk("tbl_valid_t1", 32'(result_valid), 32'd0);
      if (tbl[i].exp_gnt != '0) begin
        chk("tbl_add_in_1", add_in_1, tbl[i].a);
        chk("tbl_add_in_2", add_in_2, tbl[i].b);
      end
      @(posedge clk); #1;
      chk("tbl_valid_t2", 32'(result_valid), 32'(tbl[i].exp_gnt != '0));
      if (tbl[i].exp_gnt != '0) begin
        chk("tbl_result", result, tbl[i].exp_sum);
        chk("tbl_id", 32'(result_id), 32'(tbl[i].exp_id));
      end
      @(posedge clk); #1;
      chk("tbl_valid_t3", 32'(result_valid), 32'd0);
    end

    // Round-robin fairness: all requesting, grants rotate 0,1,2,3,...
    do_reset();
    for (int k = 0; k < 8; k++) begin
      model_cycle(4'b1111, lanes(9, 0, 32'd1000), lanes(9, 0, 32'd0), 1'b1);
      chk("rr_gnt", 32'(obs_gnt), 32'(4'b0001 << (k % 4)));
    end
    for (int k = 0; k < 3; k++) model_cycle(4'b0000, '0, '0, 1'b1);

    // Backpressure: ready low for cycles 3..6, at most one extra op queued.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      model_cycle(4'b0001, lanes(0, 32'(100 + c), 0), lanes(0, 32'd1, 0),
                  !(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("bp_gnt_held", 32'(obs_gnt), 32'd0);
    end
    for (int k = 0; k < 3; k++) model_cycle(4'b0000, '0, '0, 1'b1);

    // Pointer skip and withdraw.
    do_reset();
    model_cycle(4'b0001, lanes(0, 32'd10, 0), lanes(0, 32'd20, 0), 1'b1);
    model_cycle(4'b1001, lanes(3, 32'd30, 0), lanes(3, 32'd40, 0), 1'b1);
    chk("skip_gnt", 32'(obs_gnt), 32'(4'b1000));
    model_cycle(4'b0000, '0, '0, 1'b1);
    chk("withdraw_gnt", 32'(obs_gnt), 32'd0);
    for (int k = 0; k < 3; k++) model_cycle(4'b0000, '0, '0, 1'b1);

    // Reset mid-stream with both stages full.
    do_reset();
    for (int k = 0; k < 3; k++)
      model_cycle(4'b1111, lanes(9, 0, 32'd7), lanes(9, 0, 32'd9), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_id", 32'(result_id), 32'd0);
    chk("midrst_add_in_1", add_in_1, 32'd0);
    chk("midrst_add_in_2", add_in_2, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    mptr      = 0;
    last_cons = -100;
    model_cycle(4'b0110, lanes(1, 32'd3, 0), lanes(1, 32'd4, 0), 1'b1);
    chk("postrst_gnt", 32'(obs_gnt), 32'(4'b0010));
    for (int k = 0; k < 3; k++) model_cycle(4'b0000, '0, '0, 1'b1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [N_REQ*WIDTH-1:0] ra;
      logic [N_REQ*WIDTH-1:0] rb;
      for (int j = 0; j < N_REQ; j++) begin
        ra[j*WIDTH +: WIDTH] = $urandom;
        rb[j*WIDTH +: WIDTH] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      model_cycle(N_REQ'($urandom), ra, rb, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
